rv_div: RTL and testbench

- Iterative multi-cycle divider for RV32M DIV/DIVU/REM/REMU.
- Uses restoring radix-2 division, one quotient bit per cycle.
- Sits beside the single-cycle ALU in the execute stage. Execute stalls on o_busy and takes the result through a valid/ready handshake.
- Handles RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/rv_div.sv | 151 +++++++++++++++
 tb/tb_rv_div.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_div.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle. Divide-by-zero and signed overflow skip the iteration.
module rv_div #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] div_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            rem_sel_q;
    logic [XLEN-1:0] result_q;
    logic            valid_q;

    // Request decode, evaluated on the input operands at accept time.
    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            overflow;
    logic            accept;

    // Iteration and fix-up datapath.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        is_signed = ~i_op[0];
        sign_a    = is_signed & i_src_a[XLEN-1];
        sign_b    = is_signed & i_src_b[XLEN-1];
        abs_a     = sign_a ? -i_src_a : i_src_a;
        abs_b     = sign_b ? -i_src_b : i_src_b;
        div_zero  = (i_src_b == '0);
        overflow  = is_signed && (i_src_a == MIN_NEG) && (i_src_b == ALL_ONES);
        accept    = i_valid && (state == S_IDLE) && !i_flush;

        // The shifted remainder needs XLEN+1 bits; bit XLEN of trial is its sign.
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
        q_fix = q_neg_q ? -quo_q : quo_q;
        r_fix = r_neg_q ? -rem_q : rem_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else if (i_flush) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rem_sel_q <= i_op[1];
                        q_neg_q   <= sign_a ^ sign_b;
                        r_neg_q   <= sign_a;
                        div_q     <= abs_b;
                        if (div_zero) begin
                            result_q <= i_op[1] ? i_src_a : ALL_ONES;
                            state    <= S_DONE;
                        end else if (overflow) begin
                            result_q <= i_op[1] ? '0 : MIN_NEG;
                            state    <= S_DONE;
                        end else begin
                            rem_q <= '0;
                            quo_q <= abs_a;
                            count <= CW'(XLEN - 1);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!trial[XLEN]) begin
                        rem_q <= trial[XLEN-1:0];
                    end else begin
                        rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    end
                    quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
                    if (count == '0) begin
                        state <= S_FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S_FIX: begin
                    result_q <= rem_sel_q ? r_fix : q_fix;
                    valid_q  <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    // Special cases arrive here with valid_q still low; it rises one edge later.
                    if (valid_q && i_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = (state == S_IDLE) && !i_reset;
    assign o_busy   = (state != S_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_rv_div.sv
// Scoreboard bench for rv_div: stimulus pushes expected results, a monitor pops on each handshake.
// Directed vectors cover latency, signs, special cases, back-pressure, flush and async reset.
module tb_rv_div;

    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic            i_clk;
    logic            i_reset;
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_op;
    logic [XLEN-1:0] i_src_a;
    logic [XLEN-1:0] i_src_b;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_busy;

    int n_vec;
    int n_err;
    logic [XLEN-1:0] sb_q[$];

    rv_div #(.XLEN(XLEN)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_src_a  (i_src_a),
        .i_src_b  (i_src_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer completes on the edge following a low phase with o_valid && i_ready.
    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %h with empty scoreboard", o_result);
            end else begin
                check("result", o_result, sb_q.pop_front());
            end
        end
    end

    // Issue one request; returns after o_valid rose (latency checked) and the result drained.
    task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int n;
        @(negedge i_clk);
        check({name, "_ready"}, {31'd0, o_ready}, 32'd1);
        i_op    = op;
        i_src_a = a;
        i_src_b = b;
        i_valid = 1'b1;
        sb_q.push_back(exp);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_src_a = 32'hDEAD_BEEF;
        i_src_b = 32'h0;
        i_op    = ~op;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, lat);
        n = 0;
        while (o_valid && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check({name, "_idle_after"}, {30'd0, o_ready, o_busy}, 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_vec   = 0;
        n_err   = 0;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_op    = 2'b00;
        i_src_a = '0;
        i_src_b = '0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        check("ready_in_reset", {31'd0, o_ready}, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("reset_flags", {29'd0, o_ready, o_busy, o_valid}, 32'd4);
        check("reset_result", o_result, 32'd0);

        // Basic unsigned and signed cases.
        run_op("divu_100_7",  OP_DIVU, 32'd100,       32'd7,          32'd14,         33);
        run_op("remu_100_7",  OP_REMU, 32'd100,       32'd7,          32'd2,          33);
        run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD,  33);
        run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF,  33);
        run_op("rem_7_m2",    OP_REM,  32'd7,         32'hFFFF_FFFE,  32'd1,          33);
        run_op("div_min_2",   OP_DIV,  32'h8000_0000, 32'd2,          32'hC000_0000,  33);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          33);

        // Special cases settle without iterating.
        run_op("div_5_0",     OP_DIV,  32'd5,         32'd0,          32'hFFFF_FFFF,  1);
        run_op("remu_5_0",    OP_REMU, 32'd5,         32'd0,          32'd5,          1);
        run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  1);
        run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1);

        // Back-pressure: result held while i_ready is low.
        @(negedge i_clk);
        i_ready = 1'b0;
        i_op    = OP_DIVU;
        i_src_a = 32'd50;
        i_src_b = 32'd5;
        i_valid = 1'b1;
        sb_q.push_back(32'd10);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("hold_latency", n, 33);
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
            check("hold_flags", {30'd0, o_valid, o_ready}, 32'd2);
            check("hold_result", o_result, 32'd10);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("hold_release", {29'd0, o_ready, o_busy, o_valid}, 32'd4);

        // Flush mid-CALC discards the operation.
        @(negedge i_clk);
        i_op    = OP_DIVU;
        i_src_a = 32'd1000;
        i_src_b = 32'd3;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check("flush_busy_before", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush_idle", {29'd0, o_ready, o_busy, o_valid}, 32'd4);
        repeat (40) @(posedge i_clk);
        #1;
        check("flush_no_valid", {31'd0, o_valid}, 32'd0);

        // Flush beats a simultaneous request.
        @(negedge i_clk);
        i_op    = OP_DIVU;
        i_src_a = 32'd8;
        i_src_b = 32'd2;
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_vs_accept", {30'd0, o_busy, o_ready}, 32'd1);
        run_op("divu_9_3",    OP_DIVU, 32'd9,         32'd3,          32'd3,          33);

        // Asynchronous reset between edges mid-CALC.
        @(negedge i_clk);
        i_op    = OP_DIV;
        i_src_a = 32'd77;
        i_src_b = 32'd4;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("areset_flags", {29'd0, o_ready, o_busy, o_valid}, 32'd0);
        check("areset_result", o_result, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        check("areset_release", {29'd0, o_ready, o_busy, o_valid}, 32'd4);
        run_op("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  33);

        repeat (2) @(negedge i_clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
